// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver slice.
// funct3 encodings, ALU opcodes, flag bit positions and FSM state.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [3:0] ALU_OP_SUB = 4'b1000;
  localparam logic [3:0] ALU_OP_ADD = 4'b0000;

  // flags arrive ordered NZCV
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: (funct3, NZCV) -> {cond, illegal}.
// C = 1 means no borrow on the SUB compare (op1 >= op2 unsigned).
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       cond,
  output logic       illegal
);

  logic lt;
  assign lt = flags[FLAG_N] ^ flags[FLAG_V];

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = flags[FLAG_Z];
      F3_BNE:  cond = ~flags[FLAG_Z];
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ~flags[FLAG_C];
      F3_BGEU: cond = flags[FLAG_C];
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves RV32I conditional branches and JAL; owns the architectural PC.
// Optional BRANCH_RESOLVER_STATS_EN adds taken / not-taken counters.
module branch_resolver
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_jump,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_offset,
  output logic [3:0]  alu_op,
  input  logic [3:0]  alu_flags,
  output logic [31:0] pc,
  output logic        done_valid,
  output logic        taken,
  output logic        fault
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_not_taken
`endif
);

  state_t      state;
  logic        jump_q;
  logic [2:0]  f3_q;
  logic [31:0] off_q;
  logic [3:0]  flag_q;

  logic        cond, illegal;
  logic        bad_f3, hit, misalign, resolving;
  logic [31:0] target, pc_seq;

  branch_cond u_cond (
    .funct3  (f3_q),
    .flags   (flag_q),
    .cond    (cond),
    .illegal (illegal)
  );

  // funct3 is meaningless for a jump, so its illegal decode is masked
  always_comb begin
    bad_f3   = ~jump_q & illegal;
    hit      = jump_q | (cond & ~illegal);
    target   = pc + off_q;
    pc_seq   = pc + 32'(PC_STEP);
    misalign = hit & (target[1:0] != 2'b00);
  end

  assign resolving  = (state == RESOLVE);
  assign done_valid = resolving;
  assign taken      = resolving & hit & ~misalign;
  assign fault      = resolving & (bad_f3 | misalign);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      alu_op    <= ALU_OP_ADD;
      pc        <= RESET_PC;
      jump_q    <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 32'h0;
      flag_q    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            jump_q    <= req_jump;
            f3_q      <= req_funct3;
            off_q     <= req_offset;
            req_ready <= 1'b0;
            if (req_jump) begin
              state  <= RESOLVE;
            end else begin
              state  <= EVAL;
              alu_op <= ALU_OP_SUB;
            end
          end
        end
        EVAL: begin
          flag_q <= alu_flags;
          alu_op <= ALU_OP_ADD;
          state  <= RESOLVE;
        end
        RESOLVE: begin
          // a misaligned taken target leaves pc where it is
          if (bad_f3 || !hit) pc <= pc_seq;
          else if (!misalign) pc <= target;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          alu_op    <= ALU_OP_ADD;
        end
      endcase
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_taken     <= 32'h0;
      stat_not_taken <= 32'h0;
    end else if (done_valid && !fault) begin
      if (taken) stat_taken     <= stat_taken + 32'd1;
      else       stat_not_taken <= stat_not_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (RESET_PC = 32'h100).
// Expected values are hand-computed per vector.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_jump;
  logic [2:0]  req_funct3;
  logic [31:0] req_offset;
  logic [3:0]  alu_op;
  logic [3:0]  alu_flags;
  logic [31:0] pc;
  logic        done_valid;
  logic        taken;
  logic        fault;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_not_taken;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolver #(.RESET_PC(32'h100), .PC_STEP(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_jump   (req_jump),
    .req_funct3 (req_funct3),
    .req_offset (req_offset),
    .alu_op     (alu_op),
    .alu_flags  (alu_flags),
    .pc         (pc),
    .done_valid (done_valid),
    .taken      (taken),
    .fault      (fault)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one request, hold req_valid until done, check latency/result/pc.
  task automatic run(input string tag, input logic jump, input logic [2:0] f3,
                     input logic [31:0] off, input logic [3:0] flg,
                     input int exp_lat, input logic exp_tk, input logic exp_flt,
                     input logic [31:0] exp_pc);
    int lat;
    @(negedge clk);
    chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_jump   = jump;
    req_funct3 = f3;
    req_offset = off;
    alu_flags  = flg;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 6 && lat == 0; n++) begin
      @(negedge clk);
      if (done_valid) lat = n;
      else begin
        chk({tag, " eval_op"}, {28'b0, alu_op}, 32'h8);
        chk({tag, " idle_tf"}, {30'b0, taken, fault}, 32'd0);
      end
    end
    req_valid = 1'b0;
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " taken"}, {31'b0, taken}, {31'b0, exp_tk});
    chk({tag, " fault"}, {31'b0, fault}, {31'b0, exp_flt});
    chk({tag, " res_op"}, {28'b0, alu_op}, 32'h0);
    @(posedge clk); #1;
    chk({tag, " pc"}, pc, exp_pc);
    chk({tag, " done_lo"}, {31'b0, done_valid}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_jump   = 1'b0;
    req_funct3 = 3'b000;
    req_offset = 32'h0;
    alu_flags  = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst pc", pc, 32'h100);
    chk("rst ready", {31'b0, req_ready}, 32'd1);
    chk("rst done", {31'b0, done_valid}, 32'd0);
    chk("rst op", {28'b0, alu_op}, 32'h0);

    run("beq",   1'b0, 3'b000, 32'h20,       4'b0100, 2, 1'b1, 1'b0, 32'h120);
    run("bltu",  1'b0, 3'b110, 32'h40,       4'b0010, 2, 1'b0, 1'b0, 32'h124);
    run("bgeu",  1'b0, 3'b111, 32'h10,       4'b0010, 2, 1'b1, 1'b0, 32'h134);
    run("blt_nv",1'b0, 3'b100, 32'h8,        4'b1001, 2, 1'b0, 1'b0, 32'h138);
    run("blt_v", 1'b0, 3'b100, 32'h8,        4'b0001, 2, 1'b1, 1'b0, 32'h140);
    run("bne",   1'b0, 3'b001, 32'h8,        4'b0100, 2, 1'b0, 1'b0, 32'h144);
    run("bge_n", 1'b0, 3'b101, 32'hFFFFFFFC, 4'b1000, 2, 1'b0, 1'b0, 32'h148);
    run("bge",   1'b0, 3'b101, 32'hFFFFFFF8, 4'b0000, 2, 1'b1, 1'b0, 32'h140);
    run("f3_010",1'b0, 3'b010, 32'h8,        4'b0100, 2, 1'b0, 1'b1, 32'h144);
    run("f3_011",1'b0, 3'b011, 32'h8,        4'b0100, 2, 1'b0, 1'b1, 32'h148);
    run("jal0",  1'b1, 3'b010, 32'hFFFFFEB8, 4'b0000, 1, 1'b1, 1'b0, 32'h0);
    run("jalwr", 1'b1, 3'b000, 32'hFFFFFFFC, 4'b0000, 1, 1'b1, 1'b0, 32'hFFFFFFFC);
    run("jalmis",1'b1, 3'b000, 32'h6,        4'b0000, 1, 1'b0, 1'b1, 32'hFFFFFFFC);
    run("beqmis",1'b0, 3'b000, 32'h2,        4'b0100, 2, 1'b0, 1'b1, 32'hFFFFFFFC);

`ifdef BRANCH_RESOLVER_STATS_EN
    chk("stat_tk", stat_taken, 32'd6);
    chk("stat_nt", stat_not_taken, 32'd4);
`endif

    // reset mid-EVAL must discard the request without a done pulse
    @(negedge clk);
    req_valid  = 1'b1;
    req_jump   = 1'b0;
    req_funct3 = 3'b000;
    req_offset = 32'h40;
    alu_flags  = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    chk("mid eval_op", {28'b0, alu_op}, 32'h8);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid pc", pc, 32'h100);
    chk("mid ready", {31'b0, req_ready}, 32'd1);
    chk("mid op", {28'b0, alu_op}, 32'h0);
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("mid stat", stat_taken, 32'd0);
`endif
    @(posedge clk); #1 reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("mid nodone", {31'b0, done_valid}, 32'd0);
    end
    chk("mid pc_hold", pc, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumes the NZCV flags produced by the ALU and resolves RV32I conditional branches and JAL jumps.
- Owns the architectural PC register. Accepts one branch request at a time over a valid/ready handshake.
- Drives the ALU operation code to SUB for the compare, captures the flags, evaluates the condition, then updates the PC.
- Sits between decode and fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment for not-taken branches and illegal requests.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  decode presents a branch/jump request.
- req_ready  out  1  resolver can accept a request (high only in IDLE).
- req_jump  in  1  1 = unconditional JAL; req_funct3 is ignored.
- req_funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- req_offset  in  32  sign-extended immediate, in bytes.
- alu_op  out  4  operation code to ALU, {imm7[5], imm3} encoding.
- alu_flags  in  4  ALU flags, ordered NZCV.
- pc  out  32  current PC register.
- done_valid  out  1  one-cycle pulse when resolution completes.
- taken  out  1  qualified by done_valid; branch/jump taken.
- fault  out  1  qualified by done_valid; illegal funct3 or misaligned target.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - pc = RESET_PC.
  - state = IDLE.
  - done_valid = 0, taken = 0, fault = 0.
  - flag register = 0.
  - alu_op = 4'b0000.
  - Any in-flight request is discarded.
- States: IDLE, EVAL, RESOLVE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch jump, funct3 and offset.
  - Go to EVAL if jump = 0; go directly to RESOLVE if jump = 1.
- EVAL:
  - req_ready = 0.
  - alu_op = 4'b1000 (SUB). Decode's operands are held at the ALU by the datapath.
  - alu_flags are registered at the end of the cycle.
  - Next state RESOLVE.
- RESOLVE:
  - Condition from the registered flags:
    - BEQ: Z
    - BNE: !Z
    - BLT: N^V
    - BGE: !(N^V)
    - BLTU: !C
    - BGEU: C
  - Carry convention: C = 1 means no borrow (operand1 >= operand2 unsigned).
  - Jump: taken = 1.
  - Illegal funct3 (010, 011): fault = 1, taken = 0, pc += PC_STEP.
  - Target = pc + offset, computed modulo 2^32 (wrap-around permitted, no fault).
  - Taken with target[1:0] != 0: fault = 1, taken = 0, pc unchanged.
  - Taken and aligned: pc = target.
  - Not taken: pc += PC_STEP.
  - done_valid = 1 for this cycle only. Next state IDLE.
- Latency, with the accept edge as cycle 0:
  - Branch: done_valid in cycle 2, pc updated at the end of cycle 2.
  - Jump: done_valid in cycle 1.
- Throughput: one request per 3 cycles (branch) or per 2 cycles (jump). Back-to-back acceptance is allowed in the IDLE cycle that follows RESOLVE.
- alu_op = 4'b0000 (ADD) outside EVAL.
- req_valid while req_ready = 0 is ignored. The source must hold it; no queueing.
- taken and fault are 0 whenever done_valid = 0.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- When defined:
  - Adds outputs stat_taken[31:0] and stat_not_taken[31:0].
  - Each increments on done_valid according to taken. Faults are not counted in either.
  - Both wrap from 32'hFFFF_FFFF to 0.
  - Both are cleared by reset.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (branch_pkg), containing:
  - state enum {IDLE, EVAL, RESOLVE}.
  - funct3 constants F3_BEQ..F3_BGEU.
  - ALU_OP_SUB = 4'b1000 and ALU_OP_ADD = 4'b0000.
  - Flag bit index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
- One natural sub-module: branch_cond, a combinational evaluator mapping (funct3, flags) to {cond, illegal}. It can be unit-tested on its own.

Test Plan:
- Reset with RESET_PC = 32'h100, then deassert -> pc = 32'h100, req_ready = 1, done_valid = 0.
- BEQ, offset 32'h20, flags 4'b0100 (Z) in EVAL -> done_valid in cycle 2, taken = 1, pc = 32'h120. alu_op = 4'b1000 only during EVAL.
- BLTU, flags 4'b0010 (C = 1, no borrow) -> taken = 0, pc += 4. BGEU with the same flags -> taken = 1.
- BLT with flags N = 1, V = 1 -> taken = 0 (N^V = 0). With N = 0, V = 1 -> taken = 1.
- JAL, offset 32'hFFFF_FFFC from pc = 32'h0 -> done_valid in cycle 1, pc = 32'hFFFF_FFFC (wrap). Offset 32'h6 -> fault = 1, pc unchanged.
- funct3 = 3'b010 -> fault = 1, pc += 4. Reset asserted during EVAL -> returns to IDLE with pc = RESET_PC and no done_valid pulse.
